// File: rtl/rcswitch_tx.sv
// PT2262-style tri-state code-word transmitter.
// Serialises symbols plus a sync gap onto tx_o, one chip per tick.
module rcswitch_tx #(
    parameter int SYMBOLS = 12,
    parameter int REPEAT  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   tick_i,
    input  logic                   send_i,
    input  logic [2*SYMBOLS-1:0]   data_i,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   tx_o
);

    localparam int SW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    typedef enum logic [1:0] {IDLE, DATA, SYNC, DONE} state_t;

    state_t               state, state_n;
    logic [2*SYMBOLS-1:0] shadow, shadow_n;
    logic [2:0]           chip, chip_n;
    logic [SW-1:0]        sym, sym_n;
    logic [4:0]           syn, syn_n;
    logic [RW-1:0]        rep, rep_n;
    logic                 tx_n, done_n;

    logic [2*SYMBOLS-1:0] shifted;
    logic [1:0]           code;
    logic [7:0]           pat;

    // Current symbol is brought to the top of the shadow word.
    assign shifted = shadow << (2 * sym);
    assign code    = shifted[2*SYMBOLS-1 -: 2];

    always_comb begin
        pat = 8'h8E;
        unique case (code)
            2'b00:   pat = 8'h88;
            2'b01:   pat = 8'hEE;
            default: pat = 8'h8E;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= IDLE;
            shadow <= '0;
            chip   <= '0;
            sym    <= '0;
            syn    <= '0;
            rep    <= '0;
            tx_o   <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            chip   <= chip_n;
            sym    <= sym_n;
            syn    <= syn_n;
            rep    <= rep_n;
            tx_o   <= tx_n;
            done_o <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        chip_n   = chip;
        sym_n    = sym;
        syn_n    = syn;
        rep_n    = rep;
        tx_n     = tx_o;
        done_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (send_i) begin
                    shadow_n = data_i;
                    chip_n   = '0;
                    sym_n    = '0;
                    syn_n    = '0;
                    rep_n    = '0;
                    state_n  = DATA;
                end
            end
            DATA: begin
                if (tick_i) begin
                    tx_n   = pat[~chip];
                    chip_n = chip + 3'd1;
                    if (chip == 3'd7) begin
                        if (sym == SW'(SYMBOLS - 1)) begin
                            sym_n   = '0;
                            syn_n   = '0;
                            state_n = SYNC;
                        end else begin
                            sym_n = sym + 1'b1;
                        end
                    end
                end
            end
            SYNC: begin
                if (tick_i) begin
                    tx_n = (syn == 5'd0);
                    if (syn == 5'd31) begin
                        syn_n = '0;
                        if (int'(rep) < REPEAT - 1) begin
                            rep_n   = rep + 1'b1;
                            state_n = DATA;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        syn_n = syn + 5'd1;
                    end
                end
            end
            DONE: begin
                if (tick_i) begin
                    tx_n    = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ready_o = (state == IDLE);
    assign busy_o  = ~ready_o;

endmodule

// File: tb/tb_rcswitch_tx.sv
// Scoreboard bench for rcswitch_tx: one-frame and four-frame instances.
// Expected chips are queued at send time and popped on each busy tick.
module tb_rcswitch_tx;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick  = 1'b0;
    logic        send1 = 1'b0;
    logic        send4 = 1'b0;
    logic [23:0] data  = '0;

    logic rdy1, busy1, done1, tx1;
    logic rdy4, busy4, done4, tx4;

    typedef struct packed {
        logic tx;
        logic last;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   passed = 0;
    int   total  = 0;

    rcswitch_tx #(.SYMBOLS(12), .REPEAT(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick), .send_i(send1),
        .data_i(data), .ready_o(rdy1), .busy_o(busy1), .done_o(done1),
        .tx_o(tx1)
    );

    rcswitch_tx #(.SYMBOLS(12), .REPEAT(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick), .send_i(send4),
        .data_i(data), .ready_o(rdy4), .busy_o(busy4), .done_o(done4),
        .tx_o(tx4)
    );

    always #5 clk = ~clk;

    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            tick = (n % 4 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic [7:0] pat_of(input logic [1:0] c);
        case (c)
            2'b00:   return 8'b1000_1000;
            2'b01:   return 8'b1110_1110;
            default: return 8'b1000_1110;
        endcase
    endfunction

    task automatic push_exp(input int which, input logic [23:0] d,
                            input int reps);
        exp_t       e;
        logic [7:0] p;
        for (int r = 0; r < reps; r++) begin
            for (int s = 0; s < 12; s++) begin
                p = pat_of(d[23-2*s -: 2]);
                for (int c = 7; c >= 0; c--) begin
                    e.tx = p[c];
                    e.last = 1'b0;
                    if (which == 1) q1.push_back(e);
                    else q4.push_back(e);
                end
            end
            for (int k = 0; k < 32; k++) begin
                e.tx = (k == 0);
                e.last = 1'b0;
                if (which == 1) q1.push_back(e);
                else q4.push_back(e);
            end
        end
        e.tx = 1'b0;
        e.last = 1'b1;
        if (which == 1) q1.push_back(e);
        else q4.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        if (tick && busy1) begin
            #1;
            if (q1.size() == 0) begin
                total++;
                $display("FAIL mon1: unexpected chip %0b at %0t", tx1, $time);
            end else begin
                e = q1.pop_front();
                chk("tx1", tx1, e.tx);
                chk("done1", done1, e.last);
                chk("busy1", busy1, !e.last);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        if (tick && busy4) begin
            #1;
            if (q4.size() == 0) begin
                total++;
                $display("FAIL mon4: unexpected chip %0b at %0t", tx4, $time);
            end else begin
                e = q4.pop_front();
                chk("tx4", tx4, e.tx);
                chk("done4", done4, e.last);
                chk("busy4", busy4, !e.last);
            end
        end
    end

    task automatic send(input int which, input logic [23:0] d,
                        input bit on_tick);
        @(negedge clk);
        #1;
        if (on_tick) begin
            for (int i = 0; i < 8 && !tick; i++) begin
                @(negedge clk);
                #1;
            end
            chk("align_tick", tick, 1);
        end
        push_exp(which, d, (which == 1) ? 1 : 4);
        data = d;
        if (which == 1) send1 = 1'b1;
        else send4 = 1'b1;
        @(negedge clk);
        #1;
        send1 = 1'b0;
        send4 = 1'b0;
        if (which == 1) chk("busy1_start", busy1, 1);
        else chk("busy4_start", busy4, 1);
    endtask

    task automatic wait_done(input int which);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (which == 1 && q1.size() == 0) break;
            if (which == 4 && q4.size() == 0) break;
        end
        chk("drain", (which == 1) ? q1.size() : q4.size(), 0);
        @(posedge clk);
        #1;
        if (which == 1) begin
            chk("done1_clear", done1, 0);
            chk("ready1_back", rdy1, 1);
        end else begin
            chk("done4_clear", done4, 0);
            chk("ready4_back", rdy4, 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx1", tx1, 0);
        chk("rst_rdy1", rdy1, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_tx4", tx4, 0);
        chk("rst_rdy4", rdy4, 1);
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        rst_n = 1'b1;

        send(1, 24'h000000, 1'b0);
        wait_done(1);

        send(1, 24'h600000, 1'b0);
        wait_done(1);

        // Accepted on a tick; later sends and data changes must be ignored.
        send(4, 24'h1BE427, 1'b1);
        repeat (200) @(negedge clk);
        data = 24'hFFFFFF;
        send4 = 1'b1;
        @(negedge clk);
        send4 = 1'b0;
        repeat (700) @(negedge clk);
        data = 24'h000000;
        send4 = 1'b1;
        @(negedge clk);
        send4 = 1'b0;
        wait_done(4);

        send(4, 24'h5A5A5A, 1'b0);
        repeat (100) @(negedge clk);
        for (int i = 0; i < 60 && !tx4; i++) @(negedge clk);
        chk("find_tx_high", tx4, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx4", tx4, 0);
        chk("arst_rdy4", rdy4, 1);
        chk("arst_busy4", busy4, 0);
        q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(4, 24'h2D3C4B, 1'b0);
        wait_done(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
